// File: rtl/data_bus_nxm_arbiter.sv
// Round-robin arbitrated registered bus: NUM_SRC sources feed one
// WIDTH-bit word register delivered to one of NUM_DST destinations.
module data_bus_nxm_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 4,
   parameter int NUM_DST = 2,
   parameter int DST_W   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*WIDTH-1:0]   src_data,
   input  logic [NUM_SRC*DST_W-1:0]   src_dst,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic [NUM_DST-1:0]         dst_valid,
   output logic [WIDTH-1:0]           dst_data,
   input  logic [NUM_DST-1:0]         dst_ready,
   output logic [7:0]                 grant_id,
   output logic                       dst_err
);

   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [WIDTH-1:0]   r_data;
   logic [WIDTH-1:0]   w_data_nx;
   logic [DST_W-1:0]   r_dst;
   logic [DST_W-1:0]   w_dst_nx;
   logic [SRC_W-1:0]   r_gid;
   logic [SRC_W-1:0]   w_gid_nx;
   logic [SRC_W-1:0]   r_last;
   logic [SRC_W-1:0]   w_last_nx;
   logic               r_err;
   logic               w_err_nx;

   logic               w_cur_rdy;
   logic               w_can;
   logic               w_found;
   logic               w_acc;
   logic               w_in_rng;
   logic [SRC_W-1:0]   w_gnt;
   logic [SRC_W-1:0]   w_idx;
   logic [DST_W-1:0]   w_sel_dst;
   logic [WIDTH-1:0]   w_sel_data;

   // ready of the destination that owns the held word; others ignored
   always_comb begin
      w_cur_rdy = 1'b0;
      for (int d = 0; d < NUM_DST; d++) begin
         if (int'(r_dst) == d) w_cur_rdy = dst_ready[d];
      end
   end

   assign w_can = (r_state == IDLE) | ((r_state == HOLD) & w_cur_rdy);

   // scan sources starting just after the last winner
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_idx = SRC_W'((int'(r_last) + k) % NUM_SRC);
         if (!w_found && src_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   assign w_acc = w_can & w_found;

   // mux out the winner's word and destination index
   always_comb begin
      w_sel_dst  = '0;
      w_sel_data = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (w_gnt == SRC_W'(s)) begin
            w_sel_dst  = src_dst[s*DST_W +: DST_W];
            w_sel_data = src_data[s*WIDTH +: WIDTH];
         end
      end
   end

   assign w_in_rng = int'(w_sel_dst) < NUM_DST;

   // grant is one-hot to the winner, only when the bus can take a word
   always_comb begin
      src_ready = '0;
      if (w_acc) src_ready[w_gnt] = 1'b1;
   end

   // held word is presented to exactly one destination
   always_comb begin
      dst_valid = '0;
      for (int d = 0; d < NUM_DST; d++) begin
         dst_valid[d] = (r_state == HOLD) && (int'(r_dst) == d);
      end
   end

   assign dst_data = r_data;
   assign grant_id = 8'(r_gid);
   assign dst_err  = r_err;

   // next-state: complete, reload, or drop out-of-range words
   always_comb begin
      w_state_nx = r_state;
      w_data_nx  = r_data;
      w_dst_nx   = r_dst;
      w_gid_nx   = r_gid;
      w_last_nx  = r_last;
      w_err_nx   = 1'b0;
      if ((r_state == HOLD) && w_cur_rdy) w_state_nx = IDLE;
      if (w_acc) begin
         w_last_nx = w_gnt;
         if (w_in_rng) begin
            w_data_nx  = w_sel_data;
            w_dst_nx   = w_sel_dst;
            w_gid_nx   = w_gnt;
            w_state_nx = HOLD;
         end else begin
            w_err_nx = 1'b1;
         end
      end
   end

   // state and bus registers; pointer resets so source 0 wins first
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_dst   <= '0;
         r_gid   <= '0;
         r_last  <= SRC_W'(NUM_SRC - 1);
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_data  <= w_data_nx;
         r_dst   <= w_dst_nx;
         r_gid   <= w_gid_nx;
         r_last  <= w_last_nx;
         r_err   <= w_err_nx;
      end
   end

endmodule

// File: tb/tb_data_bus_nxm_arbiter.sv
// Scoreboard bench for data_bus_nxm_arbiter: 4 sources, 3 destinations,
// so destination index 3 exercises the drop path.
module tb_data_bus_nxm_arbiter;

   localparam int W  = 8;
   localparam int NS = 4;
   localparam int ND = 3;
   localparam int DW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NS-1:0]     src_valid = '0;
   logic [NS*W-1:0]   src_data = '0;
   logic [NS*DW-1:0]  src_dst = '0;
   logic [NS-1:0]     src_ready;
   logic [ND-1:0]     dst_valid;
   logic [W-1:0]      dst_data;
   logic [ND-1:0]     dst_ready = '0;
   logic [7:0]        grant_id;
   logic              dst_err;

   data_bus_nxm_arbiter #(
      .WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND), .DST_W(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .src_valid(src_valid),
      .src_data(src_data),
      .src_dst(src_dst),
      .src_ready(src_ready),
      .dst_valid(dst_valid),
      .dst_data(dst_data),
      .dst_ready(dst_ready),
      .grant_id(grant_id),
      .dst_err(dst_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         dst;
      int         gid;
   } word_t;

   word_t q[$];

   // reference model: is a word on the bus, where is it going,
   // who won last, and is an error pulse due this cycle
   bit m_full;
   int m_dst;
   int m_last;
   bit m_err;

   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_full = 1'b0;
      m_dst  = 0;
      m_last = NS - 1;
      m_err  = 1'b0;
   endtask

   // one bus cycle: drive inputs, check combinational and held
   // outputs, then advance the model to the next edge
   task automatic step(input logic [NS-1:0] sv, input logic [31:0] sd,
                       input logic [7:0] sdst, input logic [ND-1:0] dr);
      logic [31:0] exp_dv;
      logic [31:0] exp_sr;
      bit          can;
      bit          done;
      int          g;
      int          idx;
      int          d;
      @(negedge clk);
      src_valid = sv;
      src_data  = sd;
      src_dst   = sdst;
      dst_ready = dr;
      #1;
      exp_dv = m_full ? (32'd1 << m_dst) : 32'd0;
      chk("dst_valid", 32'(dst_valid), exp_dv);
      chk("dst_err", 32'(dst_err), 32'(m_err));
      can = !m_full || dr[m_dst];
      g = -1;
      if (can) begin
         for (int k = 1; k <= NS; k++) begin
            idx = (m_last + k) % NS;
            if (g < 0 && sv[idx]) g = idx;
         end
      end
      exp_sr = (g >= 0) ? (32'd1 << g) : 32'd0;
      chk("src_ready", 32'(src_ready), exp_sr);
      done  = m_full && dr[m_dst];
      m_err = 1'b0;
      if (done) m_full = 1'b0;
      if (g >= 0) begin
         m_last = g;
         d = int'((sdst >> (DW * g)) & 8'h3);
         if (d < ND) begin
            q.push_back('{8'((sd >> (W * g)) & 32'hff), d, g});
            m_full = 1'b1;
            m_dst  = d;
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      src_valid = '0;
      dst_ready = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_dst_valid", 32'(dst_valid), 32'd0);
      chk("rst_dst_data", 32'(dst_data), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_dst_err", 32'(dst_err), 32'd0);
   endtask

   // monitor: whenever the bus shows a word, it must be the oldest
   // expected word; a completed handshake retires it
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && dst_valid != '0) begin
            if (q.size() == 0) begin
               chk("bus_unexpected", 32'(dst_valid), 32'd0);
            end else begin
               chk("bus_data", 32'(dst_data), 32'(q[0].data));
               chk("bus_dst", 32'(dst_valid), 32'd1 << q[0].dst);
               chk("bus_grant", 32'(grant_id), 32'(q[0].gid));
               if ((dst_valid & dst_ready) != '0) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      do_reset();

      // single word to destination 1
      step(4'b0001, 32'h0000_00A5, 8'b00_00_00_01, 3'b111);
      step(4'b0000, 32'h0, 8'h0, 3'b111);
      step(4'b0000, 32'h0, 8'h0, 3'b111);

      // all sources to destination 0, full throughput rotation
      repeat (6) step(4'b1111, 32'h1312_1110, 8'h00, 3'b001);
      step(4'b0000, 32'h0, 8'h0, 3'b111);

      // back-pressure on destination 1, others keep requesting
      step(4'b0010, 32'h0000_3C00, 8'b00_00_01_00, 3'b000);
      repeat (5) step(4'b1111, 32'h4433_3C11, 8'b01_00_01_00, 3'b000);
      step(4'b1111, 32'h4433_3C11, 8'b01_00_01_00, 3'b010);
      step(4'b0000, 32'h0, 8'h0, 3'b111);

      // non-owning destination ready is ignored
      step(4'b0100, 32'h0055_0000, 8'b00_01_00_00, 3'b001);
      repeat (3) step(4'b0000, 32'h0, 8'h0, 3'b001);
      step(4'b0000, 32'h0, 8'h0, 3'b010);

      // out-of-range destination is dropped with an error pulse
      step(4'b0001, 32'h0000_0077, 8'b00_00_00_11, 3'b111);
      step(4'b0000, 32'h0, 8'h0, 3'b111);
      step(4'b0000, 32'h0, 8'h0, 3'b111);

      // reset while holding a word
      step(4'b1000, 32'hFF00_0000, 8'b00_00_00_00, 3'b000);
      step(4'b0000, 32'h0, 8'h0, 3'b000);
      do_reset();
      step(4'b1111, 32'h0403_0201, 8'h00, 3'b111);
      step(4'b0000, 32'h0, 8'h0, 3'b111);

      // randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step(NS'($urandom), $urandom, 8'($urandom),
                 ND'($urandom | $urandom));
         end
      end

      repeat (4) step(4'b0000, 32'h0, 8'h0, 3'b111);
      chk("drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
